vram_arbiter: RTL and testbench

Shares the single-port video framebuffer BRAM between the TIA pixel writer and the display scan-out reader. TIA pixel writes cannot be back-pressured because the beam races, so they go into a small write FIFO. Scan-out reads have priority and a fixed latency. A starvation guard forces a write slot after a bounded run of reads. The block sits between the TIA video outputs (`vid_out`/`vid_addr`/`vid_wr`), the HDMI/VGA scan-out engine and the framebuffer RAM.

---
 rtl/vram_arbiter_if.sv | 45 ++++
 rtl/vram_arbiter.sv | 137 +++++++++++++
 tb/tb_vram_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// Bus bundle of the framebuffer arbiter: TIA pixel write port, scan-out read
// port, framebuffer RAM port and status. master = arbiter, slave = its surroundings.
interface vram_arbiter_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 7,
  parameter int LEVEL_WIDTH = 4
);
  // TIA pixel writer: fire-and-forget strobe, never back-pressured.
  logic                   wr_stb_i;
  logic [ADDR_WIDTH-1:0]  wr_addr_i;
  logic [DATA_WIDTH-1:0]  wr_data_i;

  // Scan-out read handshake: a read transfers in every cycle where rd_req_i and
  // rd_ready_o are both high; with rd_ready_o low the request is ignored and the
  // requester holds or retries. Data returns as a single-cycle rd_valid_o pulse.
  logic                   rd_req_i;
  logic [ADDR_WIDTH-1:0]  rd_addr_i;
  logic                   rd_ready_o;
  logic                   rd_valid_o;
  logic [DATA_WIDTH-1:0]  rd_data_o;

  // Framebuffer RAM port.
  logic [ADDR_WIDTH-1:0]  mem_addr_o;
  logic                   mem_we_o;
  logic [DATA_WIDTH-1:0]  mem_wdata_o;
  logic [DATA_WIDTH-1:0]  mem_rdata_i;

  // Status and debug.
  logic [LEVEL_WIDTH-1:0] fifo_level_o;
  logic                   overflow_o;
  logic                   range_err_o;
  logic [1:0]             arb_state;

  modport master (
    input  wr_stb_i, wr_addr_i, wr_data_i, rd_req_i, rd_addr_i, mem_rdata_i,
    output rd_ready_o, rd_valid_o, rd_data_o, mem_addr_o, mem_we_o, mem_wdata_o,
           fifo_level_o, overflow_o, range_err_o, arb_state
  );

  modport slave (
    output wr_stb_i, wr_addr_i, wr_data_i, rd_req_i, rd_addr_i, mem_rdata_i,
    input  rd_ready_o, rd_valid_o, rd_data_o, mem_addr_o, mem_we_o, mem_wdata_o,
           fifo_level_o, overflow_o, range_err_o, arb_state
  );
endinterface

// File: rtl/vram_arbiter.sv
// Shares the single-port framebuffer RAM between buffered TIA pixel writes and
// priority scan-out reads, with a starvation guard that forces a write slot.
module vram_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 7,
  parameter int FB_SIZE      = 38400,
  parameter int FIFO_DEPTH   = 8,
  parameter int MAX_READ_RUN = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  vram_arbiter_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int RUN_W = $clog2(MAX_READ_RUN + 1);
  localparam int AW1   = ADDR_WIDTH + 1;

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MAX_READ_RUN - 1);
  localparam logic [AW1-1:0]   FB_LIMIT = AW1'(FB_SIZE);

  // Grant issued in the previous cycle, i.e. what the RAM port is doing now.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;

  logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [LVL_W-1:0]      level;
  logic [RUN_W-1:0]      run_cnt;
  logic                  force_wr;
  logic                  rd_pend;
  logic [1:0]            state;

  logic fifo_empty;
  logic fifo_full;
  logic in_range;
  logic grant_rd;
  logic grant_wr;
  logic push;
  logic pop;

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LVL_FULL);
  assign in_range   = ({1'b0, bus.wr_addr_i} < FB_LIMIT);

  assign bus.rd_ready_o = !force_wr;
  assign grant_rd       = bus.rd_req_i && !force_wr;
  assign grant_wr       = !grant_rd && !fifo_empty;
  assign pop            = grant_wr;
  // A full FIFO still accepts a pixel when the head leaves in the same cycle.
  assign push           = bus.wr_stb_i && in_range && (!fifo_full || pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.wr_addr_i;
      fifo_data[wr_ptr] <= bus.wr_data_i;
    end
  end

  // force_wr is raised on the edge where the run of reads reaches its limit, so
  // the very next cycle is a write slot: one write per MAX_READ_RUN+1 cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      run_cnt  <= '0;
      force_wr <= 1'b0;
    end else begin
      if (grant_wr || fifo_empty) run_cnt <= '0;
      else if (grant_rd)          run_cnt <= run_cnt + 1'b1;

      if (grant_wr)
        force_wr <= 1'b0;
      else if (grant_rd && !fifo_empty && (run_cnt == RUN_LAST))
        force_wr <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.mem_addr_o  <= '0;
      bus.mem_we_o    <= 1'b0;
      bus.mem_wdata_o <= '0;
      rd_pend         <= 1'b0;
      bus.rd_valid_o  <= 1'b0;
      state           <= ST_IDLE;
    end else begin
      rd_pend        <= grant_rd;
      bus.rd_valid_o <= rd_pend;
      if (grant_rd) begin
        bus.mem_addr_o <= bus.rd_addr_i;
        bus.mem_we_o   <= 1'b0;
        state          <= ST_RD;
      end else if (grant_wr) begin
        bus.mem_addr_o  <= fifo_addr[rd_ptr];
        bus.mem_wdata_o <= fifo_data[rd_ptr];
        bus.mem_we_o    <= 1'b1;
        state           <= ST_WR;
      end else begin
        bus.mem_we_o <= 1'b0;
        state        <= ST_IDLE;
      end
    end
  end

  // The RAM output is already registered inside the BRAM; qualifying it with
  // the registered valid keeps the N+2 latency and a zero value when idle.
  assign bus.rd_data_o = bus.rd_valid_o ? bus.mem_rdata_i : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.overflow_o  <= 1'b0;
      bus.range_err_o <= 1'b0;
    end else begin
      if (bus.wr_stb_i && in_range && fifo_full && !pop) bus.overflow_o  <= 1'b1;
      if (bus.wr_stb_i && !in_range)                     bus.range_err_o <= 1'b1;
    end
  end

  assign bus.fifo_level_o = level;
  assign bus.arb_state    = state;
endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: a queue-based model of the arbiter plus
// a framebuffer RAM, compared every cycle, and directed scenarios with literals.
module tb_vram_arbiter;
  localparam int AW     = 16;
  localparam int DW     = 7;
  localparam int DEPTH  = 8;
  localparam int LW     = 4;
  localparam int MAXRUN = 4;
  localparam int FB     = 38400;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEVEL_WIDTH(LW)) vif ();

  vram_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FB_SIZE(FB),
    .FIFO_DEPTH(DEPTH), .MAX_READ_RUN(MAXRUN)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(vif.master)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- framebuffer RAM (one-cycle registered read) ----------------
  logic [DW-1:0] ram   [65536];
  logic [DW-1:0] m_ram [65536];

  always @(posedge clk) begin
    vif.mem_rdata_i <= ram[vif.mem_addr_o];
    if (vif.mem_we_o === 1'b1) ram[vif.mem_addr_o] <= vif.mem_wdata_o;
  end

  // ---------------- behavioural model ----------------
  logic [AW-1:0]    mq_addr[$];
  logic [DW-1:0]    mq_data[$];
  logic [AW+DW-1:0] exp_q[$];
  logic [AW-1:0]    obs_wr[$];
  bit               m_force, m_stage1, m_valid, m_we, m_ovf, m_rerr;
  bit               m_gr, m_gw, m_inrng, m_full;
  int               m_reads;
  logic [AW-1:0]    m_addr;
  logic [DW-1:0]    m_wdata, m_rdata;
  bit               model_on = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mq_addr.delete(); mq_data.delete(); exp_q.delete();
      m_force = 0; m_stage1 = 0; m_valid = 0; m_we = 0; m_ovf = 0; m_rerr = 0;
      m_reads = 0; m_addr = '0; m_wdata = '0; m_rdata = '0;
    end else begin
      // what the RAM port did this cycle
      m_valid = m_stage1;
      m_rdata = m_stage1 ? m_ram[m_addr] : '0;
      if (m_we) m_ram[m_addr] = m_wdata;
      // choose next RAM access: reads first unless a write slot is owed
      m_gr    = vif.rd_req_i && !m_force;
      m_gw    = !m_gr && (mq_addr.size() > 0);
      m_inrng = (vif.wr_addr_i < FB);
      m_full  = (mq_addr.size() == DEPTH);
      if (m_gw || mq_addr.size() == 0) m_reads = 0;
      else if (m_gr) m_reads++;
      if (m_gw) m_force = 0;
      else if (m_reads == MAXRUN) m_force = 1;
      m_stage1 = m_gr;
      if (m_gr) begin
        m_addr = vif.rd_addr_i;
        m_we   = 0;
      end else if (m_gw) begin
        m_addr  = mq_addr.pop_front();
        m_wdata = mq_data.pop_front();
        m_we    = 1;
      end else begin
        m_we = 0;
      end
      if (vif.wr_stb_i) begin
        if (!m_inrng) m_rerr = 1;
        else if (m_full && !m_gw) m_ovf = 1;
        else begin
          mq_addr.push_back(vif.wr_addr_i);
          mq_data.push_back(vif.wr_data_i);
          exp_q.push_back({vif.wr_addr_i, vif.wr_data_i});
        end
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (model_on) begin
      check("rd_ready",   vif.rd_ready_o,   !m_force);
      check("fifo_level", vif.fifo_level_o, mq_addr.size());
      check("mem_we",     vif.mem_we_o,     m_we);
      check("mem_addr",   vif.mem_addr_o,   m_addr);
      check("mem_wdata",  vif.mem_wdata_o,  m_wdata);
      check("rd_valid",   vif.rd_valid_o,   m_valid);
      check("rd_data",    vif.rd_data_o,    m_rdata);
      check("overflow",   vif.overflow_o,   m_ovf);
      check("range_err",  vif.range_err_o,  m_rerr);
      if (vif.mem_we_o === 1'b1) begin
        obs_wr.push_back(vif.mem_addr_o);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL wr_order: unexpected write addr %0h data %0h", vif.mem_addr_o, vif.mem_wdata_o);
        end else begin
          check("wr_order", {vif.mem_addr_o, vif.mem_wdata_o}, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    vif.wr_stb_i  = 1'b0;
    vif.wr_addr_i = '0;
    vif.wr_data_i = '0;
    vif.rd_req_i  = 1'b0;
    vif.rd_addr_i = '0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (vif.fifo_level_o != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_done", vif.fifo_level_o, 0);
  endtask

  logic [31:0] low_mask, we_mask;
  bit          we_seen;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i]   = DW'(i * 3);
      m_ram[i] = DW'(i * 3);
    end
    ram[100]   = 7'h15;
    m_ram[100] = 7'h15;
    vif.mem_rdata_i = '0;

    // reset
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    model_on = 1'b1;
    check("rst_mem_we",    vif.mem_we_o,     0);
    check("rst_mem_addr",  vif.mem_addr_o,   0);
    check("rst_mem_wdata", vif.mem_wdata_o,  0);
    check("rst_level",     vif.fifo_level_o, 0);
    check("rst_rd_valid",  vif.rd_valid_o,   0);
    check("rst_rd_data",   vif.rd_data_o,    0);
    check("rst_overflow",  vif.overflow_o,   0);
    check("rst_range_err", vif.range_err_o,  0);
    check("rst_rd_ready",  vif.rd_ready_o,   1);
    rst = 1'b0;
    tick();

    // single write
    vif.wr_stb_i = 1'b1; vif.wr_addr_i = 16'h0010; vif.wr_data_i = 7'h2A;
    tick();
    vif.wr_stb_i = 1'b0;
    check("wr1_level_n1", vif.fifo_level_o, 1);
    check("wr1_we_n1",    vif.mem_we_o,     0);
    tick();
    check("wr1_we",    vif.mem_we_o,     1);
    check("wr1_addr",  vif.mem_addr_o,   16'h0010);
    check("wr1_wdata", vif.mem_wdata_o,  7'h2A);
    check("wr1_level", vif.fifo_level_o, 0);
    tick();
    check("wr1_we_off", vif.mem_we_o, 0);

    // read latency, then back-to-back reads
    vif.rd_req_i = 1'b1; vif.rd_addr_i = 16'd100;
    tick();
    vif.rd_req_i = 1'b0;
    check("rd_valid_n1", vif.rd_valid_o, 0);
    check("rd_addr_n1",  vif.mem_addr_o, 16'd100);
    tick();
    check("rd_valid_n2", vif.rd_valid_o, 1);
    check("rd_data_n2",  vif.rd_data_o,  7'h15);
    tick();
    check("rd_valid_n3", vif.rd_valid_o, 0);
    for (int k = 0; k < 4; k++) begin
      vif.rd_req_i = 1'b1; vif.rd_addr_i = AW'(200 + k);
      tick();
    end
    vif.rd_req_i = 1'b0;
    repeat (4) tick();

    // starvation guard: continuous reads, three writes queued alongside
    low_mask = '0; we_mask = '0; obs_wr.delete();
    for (int k = 0; k < 20; k++) begin
      vif.rd_req_i  = 1'b1;
      vif.rd_addr_i = AW'(300 + k);
      vif.wr_stb_i  = (k < 3);
      vif.wr_addr_i = AW'(16'h0400 + k);
      vif.wr_data_i = DW'(7'h30 + k);
      if (vif.rd_ready_o == 1'b0) low_mask[k] = 1'b1;
      if (vif.mem_we_o == 1'b1)   we_mask[k]  = 1'b1;
      tick();
    end
    idle_inputs();
    repeat (4) tick();
    check("guard_ready_low", low_mask, 32'h0000_8420);
    check("guard_we_cycles", we_mask,  32'h0001_0840);
    check("guard_nwrites",   obs_wr.size(), 3);
    for (int i = 0; i < obs_wr.size(); i++) check("guard_wr_addr", obs_wr[i], 32'h400 + i);

    // overflow: pushes every cycle against continuous reads
    obs_wr.delete();
    for (int k = 0; k < 12; k++) begin
      vif.rd_req_i  = 1'b1;
      vif.rd_addr_i = AW'(500 + k);
      vif.wr_stb_i  = 1'b1;
      vif.wr_addr_i = AW'(16'h0600 + k);
      vif.wr_data_i = DW'(k + 1);
      if (k == 9) begin
        check("ovf_full_level", vif.fifo_level_o, 8);
        check("ovf_not_yet",    vif.overflow_o,   0);
      end
      if (k == 10) check("ovf_set", vif.overflow_o, 1);
      tick();
    end
    check("ovf_level_end", vif.fifo_level_o, 8);
    check("ovf_sticky",    vif.overflow_o,   1);
    idle_inputs();
    wait_drain(20);
    repeat (3) tick();
    check("ovf_nwrites", obs_wr.size(), 10);
    for (int i = 0; i < obs_wr.size(); i++)
      check("ovf_wr_addr", obs_wr[i], (i < 9) ? (32'h600 + i) : 32'h60A);

    // range check
    obs_wr.delete();
    check("range_clear", vif.range_err_o, 0);
    vif.wr_stb_i = 1'b1; vif.wr_addr_i = 16'd38400; vif.wr_data_i = 7'h01;
    tick();
    vif.wr_addr_i = 16'hFFF0; vif.wr_data_i = 7'h02;
    tick();
    vif.wr_stb_i = 1'b0;
    we_seen = 1'b0;
    repeat (3) begin
      if (vif.mem_we_o == 1'b1) we_seen = 1'b1;
      tick();
    end
    check("range_err_set", vif.range_err_o,  1);
    check("range_level",   vif.fifo_level_o, 0);
    check("range_no_we",   we_seen,          0);
    vif.wr_stb_i = 1'b1; vif.wr_addr_i = 16'd38399; vif.wr_data_i = 7'h11;
    tick();
    vif.wr_stb_i = 1'b0;
    repeat (3) tick();
    check("range_edge_nwr", obs_wr.size(), 1);
    if (obs_wr.size() > 0) check("range_edge_addr", obs_wr[0], 16'd38399);

    // reset mid-operation: four queued writes, reads in flight
    obs_wr.delete();
    for (int k = 0; k < 4; k++) begin
      vif.rd_req_i  = 1'b1;
      vif.rd_addr_i = AW'(700 + k);
      vif.wr_stb_i  = 1'b1;
      vif.wr_addr_i = AW'(16'h0800 + k);
      vif.wr_data_i = DW'(7'h50 + k);
      tick();
    end
    vif.wr_stb_i = 1'b0;
    check("mid_level_4", vif.fifo_level_o, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    check("mid_we",        vif.mem_we_o,     0);
    check("mid_valid",     vif.rd_valid_o,   0);
    check("mid_level",     vif.fifo_level_o, 0);
    check("mid_overflow",  vif.overflow_o,   0);
    check("mid_range_err", vif.range_err_o,  0);
    we_seen = 1'b0;
    repeat (5) begin
      if (vif.mem_we_o == 1'b1 || vif.rd_valid_o == 1'b1) we_seen = 1'b1;
      tick();
    end
    check("mid_quiet",   we_seen,       0);
    check("mid_nwrites", obs_wr.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    n_checks++;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
